// File: rtl/clk_div_monitor_if.sv
// Signal bundle between a divided-clock source/stimulus and clk_div_monitor.
// The master side drives the divided clock and controls; the slave side is the monitor.
interface clk_div_monitor_if #(
    parameter int CNT_W = 8
);
    logic             enable;
    logic             div_in;
    logic [1:0]       ratio_sel;
    logic             locked;
    logic             err_pulse;
    logic [7:0]       err_cnt;
    logic [CNT_W-1:0] last_seg;

    modport master (
        output enable, div_in, ratio_sel,
        input  locked, err_pulse, err_cnt, last_seg
    );

    modport slave (
        input  enable, div_in, ratio_sel,
        output locked, err_pulse, err_cnt, last_seg
    );
endinterface

// File: rtl/clk_div_monitor.sv
// Checks a divided clock generated in the same clock domain: measures each high/low
// segment, declares lock after a run of correct half-periods and counts bad segments.
module clk_div_monitor #(
    parameter int CNT_W      = 8,
    parameter int LOCK_COUNT = 4
) (
    input  logic             clock,
    input  logic             reset,
    clk_div_monitor_if.slave mon
);

    typedef enum logic [1:0] {IDLE, SYNC, TRACK, LOCKED} state_t;

    state_t           state, state_nxt;
    logic             d_q;
    logic [CNT_W-1:0] run, run_nxt, half;
    logic [7:0]       good, good_nxt;
    logic [1:0]       ratio_q, ratio_nxt;
    logic             err_q, err_nxt;
    logic [7:0]       err_cnt_q, err_cnt_nxt;
    logic [CNT_W-1:0] last_seg_q, last_seg_nxt;
    logic             edge_det;

    assign edge_det = mon.enable && (mon.div_in != d_q);
    assign half     = CNT_W'(1) << ratio_q;
    assign run_nxt  = edge_det ? CNT_W'(1) : ((&run) ? run : run + CNT_W'(1));

    // Ratio change outranks segment evaluation, and SYNC discards the partial
    // segment, so a stuck level reports only one long error.
    always_comb begin
        state_nxt    = state;
        good_nxt     = good;
        ratio_nxt    = ratio_q;
        err_nxt      = 1'b0;
        last_seg_nxt = last_seg_q;
        if (!mon.enable) begin
            state_nxt = IDLE;
            good_nxt  = '0;
            ratio_nxt = mon.ratio_sel;
        end else if (state == IDLE) begin
            state_nxt = SYNC;
            good_nxt  = '0;
            ratio_nxt = mon.ratio_sel;
        end else if (mon.ratio_sel != ratio_q) begin
            state_nxt = SYNC;
            good_nxt  = '0;
            ratio_nxt = mon.ratio_sel;
        end else if (state == SYNC) begin
            if (edge_det) begin
                state_nxt = TRACK;
                good_nxt  = '0;
            end
        end else if (edge_det) begin
            last_seg_nxt = run;
            if (run == half) begin
                if (state == TRACK) begin
                    if (good == 8'(LOCK_COUNT - 1)) begin
                        state_nxt = LOCKED;
                        good_nxt  = '0;
                    end else begin
                        good_nxt = good + 8'd1;
                    end
                end
            end else begin
                err_nxt   = 1'b1;
                good_nxt  = '0;
                state_nxt = TRACK;
            end
        end else if (run >= half) begin
            err_nxt   = 1'b1;
            good_nxt  = '0;
            state_nxt = SYNC;
        end
    end

    always_comb begin
        err_cnt_nxt = err_cnt_q;
        if (err_nxt && (err_cnt_q != 8'hFF)) begin
            err_cnt_nxt = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            d_q        <= 1'b0;
            run        <= '0;
            good       <= '0;
            ratio_q    <= 2'b00;
            err_q      <= 1'b0;
            err_cnt_q  <= '0;
            last_seg_q <= '0;
        end else begin
            state      <= state_nxt;
            d_q        <= mon.div_in;
            run        <= run_nxt;
            good       <= good_nxt;
            ratio_q    <= ratio_nxt;
            err_q      <= err_nxt;
            err_cnt_q  <= err_cnt_nxt;
            last_seg_q <= last_seg_nxt;
        end
    end

    assign mon.locked    = (state == LOCKED);
    assign mon.err_pulse = err_q;
    assign mon.err_cnt   = err_cnt_q;
    assign mon.last_seg  = last_seg_q;

endmodule

// File: tb/tb_clk_div_monitor.sv
// Directed bench for clk_div_monitor: lock at several ratios, short/long errors,
// ratio change, enable/reset priority and counter saturation.
module tb_clk_div_monitor;

    logic clock;
    logic reset;
    int   checks;
    int   failures;

    clk_div_monitor_if #(.CNT_W(8)) mif ();
    clk_div_monitor_if #(.CNT_W(4)) sif ();

    clk_div_monitor #(.CNT_W(8), .LOCK_COUNT(4)) dut (
        .clock (clock),
        .reset (reset),
        .mon   (mif)
    );

    clk_div_monitor #(.CNT_W(4), .LOCK_COUNT(4)) dut_sat (
        .clock (clock),
        .reset (reset),
        .mon   (sif)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish (got timeout, expected completion)");
        $fatal(1, "[TB] watchdog");
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic d);
        mif.div_in = d;
        cyc();
    endtask

    task automatic seg(input logic lv, input int len);
        for (int i = 0; i < len; i++) applyStimulus(lv);
    endtask

    task automatic start(input logic [1:0] r);
        reset         = 1'b1;
        mif.enable    = 1'b0;
        mif.ratio_sel = r;
        applyStimulus(1'b0);
        reset      = 1'b0;
        mif.enable = 1'b1;
    endtask

    // IDLE->SYNC cycle, one synchronising edge, then four good segments
    task automatic lock_seq(input int h);
        applyStimulus(1'b0);
        seg(1'b1, h);
        seg(1'b0, h);
        seg(1'b1, h);
        seg(1'b0, h);
        seg(1'b1, h);
    endtask

    task automatic test_reset();
        reset         = 1'b1;
        mif.enable    = 1'b0;
        mif.ratio_sel = 2'b00;
        sif.enable    = 1'b0;
        sif.ratio_sel = 2'b00;
        sif.div_in    = 1'b0;
        applyStimulus(1'b0);
        applyStimulus(1'b0);
        checks++;
        if (mif.locked !== 1'b0) begin failures++; $display("[TB] FAIL reset_locked got %b expected 0", mif.locked); end
        checks++;
        if (mif.err_pulse !== 1'b0) begin failures++; $display("[TB] FAIL reset_err_pulse got %b expected 0", mif.err_pulse); end
        checks++;
        if (mif.err_cnt !== 8'd0) begin failures++; $display("[TB] FAIL reset_err_cnt got %0d expected 0", mif.err_cnt); end
        checks++;
        if (mif.last_seg !== 8'd0) begin failures++; $display("[TB] FAIL reset_last_seg got %0d expected 0", mif.last_seg); end
    endtask

    task automatic test_lock_div4();
        reset         = 1'b0;
        mif.enable    = 1'b1;
        mif.ratio_sel = 2'b01;
        seg(1'b0, 2);
        seg(1'b1, 2);
        seg(1'b0, 2);
        seg(1'b1, 2);
        seg(1'b0, 2);
        checks++;
        if (mif.locked !== 1'b0) begin failures++; $display("[TB] FAIL div4_prelock got %b expected 0", mif.locked); end
        applyStimulus(1'b1);
        checks++;
        if (mif.locked !== 1'b1) begin failures++; $display("[TB] FAIL div4_locked got %b expected 1", mif.locked); end
        checks++;
        if (mif.last_seg !== 8'd2) begin failures++; $display("[TB] FAIL div4_last_seg got %0d expected 2", mif.last_seg); end
        checks++;
        if (mif.err_cnt !== 8'd0) begin failures++; $display("[TB] FAIL div4_err_cnt got %0d expected 0", mif.err_cnt); end
    endtask

    task automatic test_div2_stuck();
        start(2'b00);
        applyStimulus(1'b0);
        applyStimulus(1'b1);
        applyStimulus(1'b0);
        applyStimulus(1'b1);
        applyStimulus(1'b0);
        checks++;
        if (mif.locked !== 1'b0) begin failures++; $display("[TB] FAIL div2_prelock got %b expected 0", mif.locked); end
        applyStimulus(1'b1);
        checks++;
        if (mif.locked !== 1'b1) begin failures++; $display("[TB] FAIL div2_locked got %b expected 1", mif.locked); end
        applyStimulus(1'b0);
        applyStimulus(1'b1);
        checks++;
        if (mif.err_pulse !== 1'b0) begin failures++; $display("[TB] FAIL div2_first_high_err got %b expected 0", mif.err_pulse); end
        applyStimulus(1'b1);
        checks++;
        if (mif.err_pulse !== 1'b1) begin failures++; $display("[TB] FAIL div2_stuck_err got %b expected 1", mif.err_pulse); end
        checks++;
        if (mif.locked !== 1'b0) begin failures++; $display("[TB] FAIL div2_stuck_unlock got %b expected 0", mif.locked); end
        checks++;
        if (mif.err_cnt !== 8'd1) begin failures++; $display("[TB] FAIL div2_stuck_cnt got %0d expected 1", mif.err_cnt); end
        applyStimulus(1'b1);
        checks++;
        if (mif.err_pulse !== 1'b0) begin failures++; $display("[TB] FAIL div2_err_width got %b expected 0", mif.err_pulse); end
        // From SYNC, four more edges must not be enough to lock
        applyStimulus(1'b0);
        applyStimulus(1'b1);
        applyStimulus(1'b0);
        applyStimulus(1'b1);
        checks++;
        if (mif.locked !== 1'b0) begin failures++; $display("[TB] FAIL div2_resync_early got %b expected 0", mif.locked); end
        applyStimulus(1'b0);
        checks++;
        if (mif.locked !== 1'b1) begin failures++; $display("[TB] FAIL div2_resync_lock got %b expected 1", mif.locked); end
    endtask

    task automatic test_short_div8();
        start(2'b10);
        lock_seq(4);
        checks++;
        if (mif.locked !== 1'b1) begin failures++; $display("[TB] FAIL div8_locked got %b expected 1", mif.locked); end
        seg(1'b0, 3);
        checks++;
        if (mif.err_pulse !== 1'b0) begin failures++; $display("[TB] FAIL div8_pre_short_err got %b expected 0", mif.err_pulse); end
        applyStimulus(1'b1);
        checks++;
        if (mif.err_pulse !== 1'b1) begin failures++; $display("[TB] FAIL div8_short_err got %b expected 1", mif.err_pulse); end
        checks++;
        if (mif.last_seg !== 8'd3) begin failures++; $display("[TB] FAIL div8_short_last_seg got %0d expected 3", mif.last_seg); end
        checks++;
        if (mif.err_cnt !== 8'd1) begin failures++; $display("[TB] FAIL div8_short_cnt got %0d expected 1", mif.err_cnt); end
        checks++;
        if (mif.locked !== 1'b0) begin failures++; $display("[TB] FAIL div8_short_unlock got %b expected 0", mif.locked); end
        applyStimulus(1'b1);
        checks++;
        if (mif.err_pulse !== 1'b0) begin failures++; $display("[TB] FAIL div8_err_width got %b expected 0", mif.err_pulse); end
        seg(1'b1, 2);
        seg(1'b0, 4);
        seg(1'b1, 4);
        seg(1'b0, 4);
        checks++;
        if (mif.locked !== 1'b0) begin failures++; $display("[TB] FAIL div8_relock_early got %b expected 0", mif.locked); end
        applyStimulus(1'b1);
        checks++;
        if (mif.locked !== 1'b1) begin failures++; $display("[TB] FAIL div8_relock got %b expected 1", mif.locked); end
        checks++;
        if (mif.last_seg !== 8'd4) begin failures++; $display("[TB] FAIL div8_relock_last_seg got %0d expected 4", mif.last_seg); end
    endtask

    task automatic test_ratio_change();
        logic any_err;
        start(2'b01);
        lock_seq(2);
        checks++;
        if (mif.locked !== 1'b1) begin failures++; $display("[TB] FAIL ratio_locked got %b expected 1", mif.locked); end
        mif.ratio_sel = 2'b10;
        applyStimulus(1'b0);
        checks++;
        if (mif.locked !== 1'b0) begin failures++; $display("[TB] FAIL ratio_unlock got %b expected 0", mif.locked); end
        any_err = mif.err_pulse;
        for (int i = 0; i < 3; i++) begin applyStimulus(1'b0); any_err |= mif.err_pulse; end
        for (int s = 0; s < 4; s++) begin
            for (int i = 0; i < 4; i++) begin
                applyStimulus((s % 2) == 0);
                any_err |= mif.err_pulse;
            end
        end
        checks++;
        if (mif.locked !== 1'b0) begin failures++; $display("[TB] FAIL ratio_relock_early got %b expected 0", mif.locked); end
        applyStimulus(1'b1);
        any_err |= mif.err_pulse;
        checks++;
        if (mif.locked !== 1'b1) begin failures++; $display("[TB] FAIL ratio_relock got %b expected 1", mif.locked); end
        checks++;
        if (any_err !== 1'b0) begin failures++; $display("[TB] FAIL ratio_no_err got %b expected 0", any_err); end
        checks++;
        if (mif.err_cnt !== 8'd0) begin failures++; $display("[TB] FAIL ratio_err_cnt got %0d expected 0", mif.err_cnt); end
    endtask

    task automatic test_enable_reset();
        start(2'b01);
        lock_seq(2);
        applyStimulus(1'b0);
        applyStimulus(1'b1);
        checks++;
        if (mif.err_pulse !== 1'b1) begin failures++; $display("[TB] FAIL en_short_err got %b expected 1", mif.err_pulse); end
        checks++;
        if (mif.last_seg !== 8'd1) begin failures++; $display("[TB] FAIL en_short_last_seg got %0d expected 1", mif.last_seg); end
        applyStimulus(1'b1);
        seg(1'b0, 2);
        seg(1'b1, 2);
        seg(1'b0, 2);
        applyStimulus(1'b1);
        checks++;
        if (mif.locked !== 1'b1) begin failures++; $display("[TB] FAIL en_relock got %b expected 1", mif.locked); end
        mif.enable = 1'b0;
        applyStimulus(1'b1);
        checks++;
        if (mif.locked !== 1'b0) begin failures++; $display("[TB] FAIL en_disable_unlock got %b expected 0", mif.locked); end
        applyStimulus(1'b0);
        applyStimulus(1'b1);
        applyStimulus(1'b0);
        checks++;
        if (mif.err_cnt !== 8'd1) begin failures++; $display("[TB] FAIL en_hold_err_cnt got %0d expected 1", mif.err_cnt); end
        checks++;
        if (mif.last_seg !== 8'd2) begin failures++; $display("[TB] FAIL en_hold_last_seg got %0d expected 2", mif.last_seg); end
        checks++;
        if (mif.err_pulse !== 1'b0) begin failures++; $display("[TB] FAIL en_idle_err got %b expected 0", mif.err_pulse); end
        mif.enable = 1'b1;
        reset      = 1'b1;
        applyStimulus(1'b1);
        reset = 1'b0;
        checks++;
        if ({mif.locked, mif.err_pulse, mif.err_cnt, mif.last_seg} !== 18'd0) begin
            failures++;
            $display("[TB] FAIL midrun_reset got locked=%b err=%b cnt=%0d seg=%0d expected all 0",
                     mif.locked, mif.err_pulse, mif.err_cnt, mif.last_seg);
        end
    endtask

    task automatic test_saturation();
        logic lv;
        start(2'b11);
        applyStimulus(1'b0);
        applyStimulus(1'b1);
        lv = 1'b1;
        for (int k = 1; k <= 300; k++) begin
            lv = ~lv;
            applyStimulus(lv);
            if (k == 10) begin
                checks++;
                if (mif.err_cnt !== 8'd10) begin failures++; $display("[TB] FAIL sat_cnt_10 got %0d expected 10", mif.err_cnt); end
            end
            if (k == 254) begin
                checks++;
                if (mif.err_cnt !== 8'd254) begin failures++; $display("[TB] FAIL sat_cnt_254 got %0d expected 254", mif.err_cnt); end
            end
        end
        checks++;
        if (mif.err_cnt !== 8'd255) begin failures++; $display("[TB] FAIL sat_cnt_255 got %0d expected 255", mif.err_cnt); end

        reset         = 1'b1;
        sif.enable    = 1'b0;
        sif.ratio_sel = 2'b11;
        sif.div_in    = 1'b0;
        cyc();
        reset      = 1'b0;
        sif.enable = 1'b1;
        cyc();
        sif.div_in = 1'b1;
        cyc();
        for (int k = 1; k <= 40; k++) begin
            cyc();
            if (k == 7) begin
                checks++;
                if (sif.err_pulse !== 1'b0) begin failures++; $display("[TB] FAIL stuck_early_err got %b expected 0", sif.err_pulse); end
            end
            if (k == 8) begin
                checks++;
                if (sif.err_pulse !== 1'b1) begin failures++; $display("[TB] FAIL stuck_long_err got %b expected 1", sif.err_pulse); end
            end
        end
        checks++;
        if (dut_sat.run !== 4'd15) begin failures++; $display("[TB] FAIL stuck_run_sat got %0d expected 15", dut_sat.run); end
        checks++;
        if (sif.err_cnt !== 8'd1) begin failures++; $display("[TB] FAIL stuck_single_err got %0d expected 1", sif.err_cnt); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_lock_div4();
        test_div2_stuck();
        test_short_div8();
        test_ratio_change();
        test_enable_reset();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
